axil_reg_bank: RTL and testbench
================================

Name: axil_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank that terminates the PS general-purpose master port (USER_AXI_*) in the PL top level.
- Provides NUM_CTRL read/write control registers with byte-strobe support and per-register one-cycle write pulses.
- Provides NUM_STAT read-only status registers sampled from fabric inputs.
- Returns SLVERR for unmapped addresses.
- Successor to the bare PS wrapper: generalises register count, address width and reset values, and adds error decode.

Parameters:
AXI_ADDR_W, 31, width of USER_AXI_awaddr/araddr
NUM_CTRL, 8, number of RW control registers (1..64)
NUM_STAT, 8, number of RO status registers (0..64)
CTRL_RST_VAL, 32'h0000_0000, reset value of every control register

Ports:
AXI_CLK  in  1  single clock for all logic
AXI_RSTN  in  1  asynchronous active-low reset
USER_AXI_awaddr  in  AXI_ADDR_W  write address
USER_AXI_awprot  in  3  ignored
USER_AXI_awvalid / USER_AXI_awready  in / out  1  AW handshake
USER_AXI_wdata  in  32  write data
USER_AXI_wstrb  in  4  byte strobes
USER_AXI_wvalid / USER_AXI_wready  in / out  1  W handshake
USER_AXI_bresp  out  2  write response
USER_AXI_bvalid / USER_AXI_bready  out / in  1  B handshake
USER_AXI_araddr  in  AXI_ADDR_W  read address
USER_AXI_arprot  in  3  ignored
USER_AXI_arvalid / USER_AXI_arready  in / out  1  AR handshake
USER_AXI_rdata  out  32  read data
USER_AXI_rresp  out  2  read response
USER_AXI_rvalid / USER_AXI_rready  out / in  1  R handshake
ctrl_regs  out  NUM_CTRL*32  control register contents, reg i at bits [32i+31:32i]
ctrl_wr_pulse  out  NUM_CTRL  one-cycle pulse, register i written
stat_regs  in  NUM_STAT*32  status inputs, already in AXI_CLK domain

Behaviour:
Reset:
- While AXI_RSTN is low, asynchronously: all ready/valid outputs 0; bresp/rresp 2'b00; rdata 0; ctrl_regs = CTRL_RST_VAL; ctrl_wr_pulse 0.
- Reset asserted mid-transaction abandons it. No response is issued after release.
- awready and wready rise in the first cycle after release; arready likewise.

Address decode:
- idx = addr[7:2]. Bits [1:0] and bits above 7 are ignored; the interconnect does base decode.
- idx < NUM_CTRL: control register idx.
- NUM_CTRL <= idx < NUM_CTRL+NUM_STAT: status register idx-NUM_CTRL.
- Otherwise: unmapped.

Write channel:
- AW and W are accepted independently. awready=1 while no AW is held and bvalid=0; wready likewise for W.
- Either channel may arrive first, in any order; the first one is held until the other arrives.
- Edge E at which both are held, or both handshake together: perform the write.
  - Control target: bytes with wstrb set are updated; bresp=OKAY.
  - Status or unmapped target: no state change; bresp=SLVERR (2'b10).
  - bvalid=1 and ctrl_wr_pulse[idx]=1 in the cycle after E. The pulse fires only for control targets and even when wstrb=0.
  - The new value is visible on ctrl_regs in the same cycle as the pulse.
- bvalid holds until bready. AW/W are not accepted while bvalid=1.
- Max throughput: one write per 2 cycles.

Read channel:
- arready = !rvalid.
- On AR handshake at edge E:
  - rdata is registered from the selected register; status inputs are sampled at E.
  - rresp = OKAY for mapped targets; SLVERR with rdata=0 for unmapped.
  - rvalid=1 in the next cycle and holds, with rdata/rresp stable, until rready.
- One outstanding read; max one read per 2 cycles.

Simultaneous events:
- Read and write to the same control register on the same edge: the read returns the pre-write value.
- Read and write channels are otherwise fully independent and may complete in the same cycle.

Decomposition:
- Package axil_pkg holds:
  - localparams RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - DATA_W=32 and STRB_W=4;
  - the function idx_of(addr) returning addr[7:2].
- The read mux is a single combinational case/index inside the module. No sub-module is needed.
- The write-capture FSM (IDLE / HAVE_AW / HAVE_W / RESP) lives inline.

Test Plan:
1. Reset, then write 32'hDEAD_BEEF to 0x04 with AW and W in the same cycle, wstrb=4'hF -> bvalid the next cycle, bresp=00, ctrl_wr_pulse[1] for one cycle, ctrl_regs reg1=DEAD_BEEF; read 0x04 returns DEAD_BEEF, rresp=00.
2. W presented 3 cycles before AW, wdata=32'h1234_5678, wstrb=4'b0101, reg0 preset to 32'hFFFF_FFFF -> reg0 reads 32'hFF34_FF78; awready/wready stay low until bready.
3. Write to status index 8 (addr 0x20) and to unmapped 0x80 with defaults -> bresp=10 for both, no ctrl_wr_pulse, no register changes; read 0x80 gives rresp=10, rdata=0.
4. stat_regs reg0 driven to 32'hA5A5_0001, read 0x20 with rready held low for 5 cycles while stat_regs changes -> rdata holds A5A5_0001 and rvalid stays high until rready; arready=0 throughout.
5. Same-edge read and write of reg2 (old 32'h0, new 32'h7) -> the read returns 0; a following read returns 7.
6. Assert AXI_RSTN low while bvalid is pending -> bvalid drops immediately, all ctrl_regs return to CTRL_RST_VAL, and no B response is issued after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared constants and address helpers for the AXI4-Lite register bank.
package axil_pkg;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [5:0] idx_of(input logic [31:0] addr);
    return addr[7:2];
  endfunction
endpackage

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave exposing RW control registers with write pulses and RO status registers.
// Unmapped word indices answer SLVERR; the interconnect already did base decode.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | nothing held, both AW and W may be accepted
// S_HAVE_AW| address held, waiting for write data
// S_HAVE_W | write data held, waiting for address
// S_RESP   | write done, B response pending until bready
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int          AXI_ADDR_W   = 31,
  parameter int          NUM_CTRL     = 8,
  parameter int          NUM_STAT     = 8,
  parameter logic [31:0] CTRL_RST_VAL = 32'h0000_0000
) (
  input  logic                                   AXI_CLK,
  input  logic                                   AXI_RSTN,
  input  logic [AXI_ADDR_W-1:0]                  USER_AXI_awaddr,
  input  logic [2:0]                             USER_AXI_awprot,
  input  logic                                   USER_AXI_awvalid,
  output logic                                   USER_AXI_awready,
  input  logic [31:0]                            USER_AXI_wdata,
  input  logic [3:0]                             USER_AXI_wstrb,
  input  logic                                   USER_AXI_wvalid,
  output logic                                   USER_AXI_wready,
  output logic [1:0]                             USER_AXI_bresp,
  output logic                                   USER_AXI_bvalid,
  input  logic                                   USER_AXI_bready,
  input  logic [AXI_ADDR_W-1:0]                  USER_AXI_araddr,
  input  logic [2:0]                             USER_AXI_arprot,
  input  logic                                   USER_AXI_arvalid,
  output logic                                   USER_AXI_arready,
  output logic [31:0]                            USER_AXI_rdata,
  output logic [1:0]                             USER_AXI_rresp,
  output logic                                   USER_AXI_rvalid,
  input  logic                                   USER_AXI_rready,
  output logic [NUM_CTRL*32-1:0]                 ctrl_regs,
  output logic [NUM_CTRL-1:0]                    ctrl_wr_pulse,
  input  logic [(NUM_STAT > 0 ? NUM_STAT : 1)*32-1:0] stat_regs
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HAVE_AW = 2'd1;
  localparam logic [1:0] S_HAVE_W  = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]             state;
  logic                   rst_done;
  logic [5:0]             aw_idx_q;
  logic [DATA_W-1:0]      w_data_q;
  logic [STRB_W-1:0]      w_strb_q;
  logic [1:0]             bresp_q;
  logic [NUM_CTRL*32-1:0] ctrl_q;
  logic                   rvalid_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [1:0]             rresp_q;

  logic                   aw_rdy, w_rdy, ar_rdy;
  logic                   aw_hs, w_hs, ar_hs;
  logic                   wr_fire, wr_ctrl;
  logic [5:0]             wr_idx, rd_idx;
  logic [DATA_W-1:0]      wr_data;
  logic [STRB_W-1:0]      wr_strb;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_err;
  logic                   unused_prot;

  assign unused_prot = ^{USER_AXI_awprot, USER_AXI_arprot};

  // rst_done keeps every ready low until the first edge after reset release
  assign aw_rdy = rst_done && (state == S_IDLE || state == S_HAVE_W);
  assign w_rdy  = rst_done && (state == S_IDLE || state == S_HAVE_AW);
  assign ar_rdy = rst_done && !rvalid_q;

  assign aw_hs = USER_AXI_awvalid && aw_rdy;
  assign w_hs  = USER_AXI_wvalid && w_rdy;
  assign ar_hs = USER_AXI_arvalid && ar_rdy;

  assign wr_fire = (state == S_IDLE && aw_hs && w_hs) ||
                   (state == S_HAVE_AW && w_hs) ||
                   (state == S_HAVE_W && aw_hs);
  assign wr_idx  = (state == S_HAVE_AW) ? aw_idx_q : idx_of(32'(USER_AXI_awaddr));
  assign wr_data = (state == S_HAVE_W) ? w_data_q : USER_AXI_wdata;
  assign wr_strb = (state == S_HAVE_W) ? w_strb_q : USER_AXI_wstrb;
  assign wr_ctrl = int'(wr_idx) < NUM_CTRL;

  assign rd_idx = idx_of(32'(USER_AXI_araddr));

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (int'(rd_idx) == i) begin
        rd_data = ctrl_q[32*i +: 32];
        rd_err  = 1'b0;
      end
    end
    for (int i = 0; i < NUM_STAT; i++) begin
      if (int'(rd_idx) == NUM_CTRL + i) begin
        rd_data = stat_regs[32*i +: 32];
        rd_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge AXI_CLK or negedge AXI_RSTN) begin
    if (!AXI_RSTN) begin
      rst_done      <= 1'b0;
      state         <= S_IDLE;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      bresp_q       <= RESP_OKAY;
      ctrl_q        <= {NUM_CTRL{CTRL_RST_VAL}};
      ctrl_wr_pulse <= '0;
    end else begin
      rst_done <= 1'b1;
      if (aw_hs) aw_idx_q <= idx_of(32'(USER_AXI_awaddr));
      if (w_hs) begin
        w_data_q <= USER_AXI_wdata;
        w_strb_q <= USER_AXI_wstrb;
      end

      case (state)
        S_IDLE: begin
          if (aw_hs && w_hs) state <= S_RESP;
          else if (aw_hs)    state <= S_HAVE_AW;
          else if (w_hs)     state <= S_HAVE_W;
        end
        S_HAVE_AW: if (w_hs) state <= S_RESP;
        S_HAVE_W:  if (aw_hs) state <= S_RESP;
        default:   if (USER_AXI_bready) state <= S_IDLE;
      endcase

      for (int i = 0; i < NUM_CTRL; i++) begin
        ctrl_wr_pulse[i] <= wr_fire && (int'(wr_idx) == i);
        if (wr_fire && int'(wr_idx) == i) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) ctrl_q[32*i + 8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end

      if (wr_fire) bresp_q <= wr_ctrl ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read path samples the pre-write register contents on a same-edge collision
  always_ff @(posedge AXI_CLK or negedge AXI_RSTN) begin
    if (!AXI_RSTN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && USER_AXI_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign USER_AXI_awready = aw_rdy;
  assign USER_AXI_wready  = w_rdy;
  assign USER_AXI_arready = ar_rdy;
  assign USER_AXI_bvalid  = (state == S_RESP);
  assign USER_AXI_bresp   = bresp_q;
  assign USER_AXI_rvalid  = rvalid_q;
  assign USER_AXI_rdata   = rdata_q;
  assign USER_AXI_rresp   = rresp_q;
  assign ctrl_regs        = ctrl_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: handshakes, strobes, error decode, collisions, reset abort.
module tb_axil_reg_bank;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [30:0]  awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata = '0, rdata;
  logic [3:0]   wstrb = '0;
  logic [1:0]   bresp, rresp;
  logic [255:0] ctrl_regs;
  logic [7:0]   ctrl_wr_pulse;
  logic [255:0] stat_regs = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ctrl [8];
  logic [31:0] rd_d;
  logic [1:0]  rd_r;

  always #5 clk = ~clk;

  axil_reg_bank dut (
    .AXI_CLK(clk), .AXI_RSTN(rst_n),
    .USER_AXI_awaddr(awaddr), .USER_AXI_awprot(awprot),
    .USER_AXI_awvalid(awvalid), .USER_AXI_awready(awready),
    .USER_AXI_wdata(wdata), .USER_AXI_wstrb(wstrb),
    .USER_AXI_wvalid(wvalid), .USER_AXI_wready(wready),
    .USER_AXI_bresp(bresp), .USER_AXI_bvalid(bvalid), .USER_AXI_bready(bready),
    .USER_AXI_araddr(araddr), .USER_AXI_arprot(arprot),
    .USER_AXI_arvalid(arvalid), .USER_AXI_arready(arready),
    .USER_AXI_rdata(rdata), .USER_AXI_rresp(rresp),
    .USER_AXI_rvalid(rvalid), .USER_AXI_rready(rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .stat_regs(stat_regs)
  );

  function automatic logic [255:0] exp_pack();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = exp_ctrl[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [30:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 0;
    w_done  = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      @(negedge clk);
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs)  begin wvalid = 0;  w_done = 1;  end
    end
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
  endtask

  task automatic b_ack();
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [30:0] a, output logic [31:0] d, output logic [1:0] r);
    logic done, hs;
    done = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      if (hs) begin arvalid = 0; done = 1; end
    end
    chk("rd_handshake", done, 1'b1);
    @(negedge clk);
    chk("rd_rvalid", rvalid, 1'b1);
    d = rdata;
    r = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_ctrl[i] = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_ctrl", ctrl_regs, exp_pack());
    chk("rst_pulse", ctrl_wr_pulse, 8'h00);
    rst_n = 1;
    @(negedge clk);
    chk("rel_readies", {awready, wready, arready}, 3'b111);

    // 1: aligned write then readback
    axi_write(31'h04, 32'hDEAD_BEEF, 4'hF);
    exp_ctrl[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_bvalid", bvalid, 1'b1);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_pulse", ctrl_wr_pulse, 8'h02);
    chk("t1_ctrl", ctrl_regs, exp_pack());
    b_ack();
    @(negedge clk);
    chk("t1_pulse_gone", ctrl_wr_pulse, 8'h00);
    chk("t1_bvalid_gone", bvalid, 1'b0);
    axi_read(31'h04, rd_d, rd_r);
    chk("t1_rdata", rd_d, 32'hDEAD_BEEF);
    chk("t1_rresp", rd_r, 2'b00);

    // 2: W leads AW by three cycles, partial strobes
    axi_write(31'h00, 32'hFFFF_FFFF, 4'hF);
    b_ack();
    exp_ctrl[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    wdata = 32'h1234_5678; wstrb = 4'b0101; wvalid = 1;
    @(negedge clk);
    chk("t2_w_first_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    wvalid = 0;
    repeat (2) begin
      @(negedge clk);
      chk("t2_wready_held", {awready, wready}, 2'b10);
      @(posedge clk); #1;
    end
    awaddr = 31'h00; awvalid = 1;
    @(negedge clk);
    chk("t2_awready", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 0;
    exp_ctrl[0] = 32'hFF34_FF78;
    @(negedge clk);
    chk("t2_bvalid", {bvalid, bresp}, 3'b100);
    chk("t2_pulse", ctrl_wr_pulse, 8'h01);
    chk("t2_ctrl", ctrl_regs, exp_pack());
    repeat (2) begin
      @(negedge clk);
      chk("t2_blocked", {bvalid, awready, wready}, 3'b100);
    end
    b_ack();
    @(negedge clk);
    chk("t2_reopen", {bvalid, awready, wready}, 3'b011);
    axi_read(31'h00, rd_d, rd_r);
    chk("t2_rdata", rd_d, 32'hFF34_FF78);

    // 3: status and unmapped writes rejected
    axi_write(31'h20, 32'h5555_AAAA, 4'hF);
    @(negedge clk);
    chk("t3_stat_bresp", {bvalid, bresp}, 3'b110);
    chk("t3_stat_pulse", ctrl_wr_pulse, 8'h00);
    b_ack();
    axi_write(31'h80, 32'h1111_2222, 4'hF);
    @(negedge clk);
    chk("t3_unmap_bresp", {bvalid, bresp}, 3'b110);
    chk("t3_unmap_pulse", ctrl_wr_pulse, 8'h00);
    chk("t3_ctrl_same", ctrl_regs, exp_pack());
    b_ack();
    axi_read(31'h80, rd_d, rd_r);
    chk("t3_rd_unmap_resp", rd_r, 2'b10);
    chk("t3_rd_unmap_data", rd_d, 32'h0);

    // 4: status read held by rready while input moves
    stat_regs[31:0] = 32'hA5A5_0001;
    @(posedge clk); #1;
    araddr = 31'h20; arvalid = 1;
    @(negedge clk);
    chk("t4_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    for (int k = 0; k < 5; k++) begin
      stat_regs[31:0] = 32'h0BAD_0000 + 32'(k);
      @(negedge clk);
      chk("t4_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, 32'hA5A5_0001});
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    chk("t4_released", {rvalid, arready}, 2'b01);

    // 5: same-edge read and write of reg2
    @(posedge clk); #1;
    awaddr = 31'h08; wdata = 32'h7; wstrb = 4'hF; araddr = 31'h08;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    chk("t5_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_ctrl[2] = 32'h7;
    @(negedge clk);
    chk("t5_both_valid", {rvalid, bvalid}, 2'b11);
    chk("t5_old_value", rdata, 32'h0);
    chk("t5_pulse", ctrl_wr_pulse, 8'h04);
    chk("t5_ctrl", ctrl_regs, exp_pack());
    rready = 1; bready = 1;
    @(posedge clk); #1;
    rready = 0; bready = 0;
    axi_read(31'h08, rd_d, rd_r);
    chk("t5_new_value", rd_d, 32'h7);

    // 6: reset while B is pending
    axi_write(31'h0C, 32'h0BAD_F00D, 4'hF);
    exp_ctrl[3] = 32'h0BAD_F00D;
    @(negedge clk);
    chk("t6_pending", bvalid, 1'b1);
    chk("t6_written", ctrl_regs, exp_pack());
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 8; i++) exp_ctrl[i] = 32'h0;
    chk("t6_bvalid_drop", bvalid, 1'b0);
    chk("t6_ctrl_reset", ctrl_regs, exp_pack());
    chk("t6_readies", {awready, wready, arready}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_bresp", bvalid, 1'b0);
    end
    chk("t6_awready", awready, 1'b1);
    axi_read(31'h0C, rd_d, rd_r);
    chk("t6_reg3_reset", rd_d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
